// File: rtl/mipi_rx_link_ctrl.sv
// MIPI CSI-2 receive link controller.
// Sequences D-PHY power-down/reset and PLL lock, then checks frame/line
// timing. Also gates a frame-counted capture window.
// Optional build macro MIPI_LINK_STATS_EN: adds a saturating count of
// frame_err_o pulses on err_cnt_o. Without it, err_cnt_o is tied to zero.
module mipi_rx_link_ctrl #(
  parameter int unsigned PD_CYCLES      = 16,
  parameter int unsigned RST_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned EXP_LINES      = 480,
  parameter int unsigned EXP_PIXELS     = 640
) (
  input  logic        clk_pixel_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        pll_lock_i,
  input  logic        fv_i,
  input  logic        lv_i,
  input  logic        capture_req_i,
  input  logic [7:0]  capture_frames_i,
  output logic        dphy_pd_o,
  output logic        dphy_reset_n_o,
  output logic        link_up_o,
  output logic        capture_en_o,
  output logic        capture_busy_o,
  output logic        frame_done_o,
  output logic        frame_err_o,
  output logic [15:0] frame_cnt_o,
  output logic [11:0] line_cnt_o,
  output logic [15:0] err_cnt_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    PWRDN     = 3'd1,
    RST       = 3'd2,
    WAIT_LOCK = 3'd3,
    SYNC      = 3'd4,
    LIVE      = 3'd5
  } state_t;

  localparam logic [23:0] PD_LAST      = 24'(PD_CYCLES - 1);
  localparam logic [23:0] RST_LAST     = 24'(RST_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0] EXP_L        = 12'(EXP_LINES);
  localparam logic [11:0] EXP_P        = 12'(EXP_PIXELS);

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state, state_nxt;
  logic [23:0] tmr;
  logic        fv_p1, lv_p1;
  logic        fv_rise, fv_fall, lv_rise, lv_fall;
  logic        watch, timeout, live, leave_live;
  logic [11:0] line_run, line_base, line_nxt;
  logic [11:0] pix_run, pix_nxt;
  logic        pix_err, pix_err_nxt;
  logic        frame_end, frame_bad, abort, err_pulse;
  logic        accept;
  logic [7:0]  cap_rem;

  assign fv_rise = fv_i & ~fv_p1;
  assign fv_fall = ~fv_i & fv_p1;
  assign lv_rise = lv_i & ~lv_p1;
  assign lv_fall = ~lv_i & lv_p1;

  // The frame-start watchdog runs only while the PHY is out of reset; any
  // fv rise counts as proof of life and restarts it.
  assign watch   = (state == WAIT_LOCK) || (state == SYNC) || (state == LIVE);
  assign timeout = watch && (tmr >= TIMEOUT_LAST) && !fv_rise;
  assign live    = (state == LIVE);

  // Next-state selection; disable outranks timeout, which outranks the rest
  always_comb begin
    state_nxt = state;
    case (state)
      OFF:       if (enable_i) state_nxt = PWRDN;
      PWRDN:     if (tmr >= PD_LAST) state_nxt = RST;
      RST:       if (tmr >= RST_LAST) state_nxt = WAIT_LOCK;
      WAIT_LOCK: if (pll_lock_i) state_nxt = SYNC;
      SYNC:      if (fv_rise) state_nxt = LIVE;
      LIVE:      if (!pll_lock_i) state_nxt = PWRDN;
      default:   state_nxt = OFF;
    endcase
    if (timeout) state_nxt = PWRDN;
    if (!enable_i) state_nxt = OFF;
  end

  assign leave_live = live && (state_nxt != LIVE);

  // Line and pixel accounting for the frame currently on the wire
  always_comb begin
    line_base = fv_rise ? 12'd0 : line_run;
    line_nxt  = line_base;
    if (live && lv_rise) line_nxt = sat_inc12(line_base);

    pix_nxt = pix_run;
    if (live && lv_rise)   pix_nxt = 12'd1;
    else if (live && lv_i) pix_nxt = sat_inc12(pix_run);

    pix_err_nxt = fv_rise ? 1'b0 : pix_err;
    if (live && lv_fall && (pix_run != EXP_P)) pix_err_nxt = 1'b1;
  end

  // A frame aborted by leaving LIVE reports an error instead of completing
  assign frame_end = live && fv_fall && !leave_live;
  assign frame_bad = (line_nxt != EXP_L) || pix_err_nxt;
  assign abort     = leave_live && (fv_p1 || fv_i);
  assign err_pulse = (frame_end && frame_bad) || abort;
  assign accept    = live && !capture_busy_o && capture_req_i &&
                     (capture_frames_i != 8'd0);

  // State register, hold timer and registered PHY control outputs
  always_ff @(posedge clk_pixel_i) begin
    if (reset_i) begin
      state          <= OFF;
      tmr            <= '0;
      dphy_pd_o      <= 1'b1;
      dphy_reset_n_o <= 1'b0;
      link_up_o      <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || (watch && fv_rise) || (state == OFF))
        tmr <= '0;
      else
        tmr <= tmr + 24'd1;
      dphy_pd_o      <= (state_nxt == OFF) || (state_nxt == PWRDN);
      dphy_reset_n_o <= (state_nxt == WAIT_LOCK) || (state_nxt == SYNC) ||
                        (state_nxt == LIVE);
      link_up_o      <= (state_nxt == LIVE);
    end
  end

  // Edge history, frame counters and frame status pulses
  always_ff @(posedge clk_pixel_i) begin
    if (reset_i) begin
      fv_p1        <= 1'b0;
      lv_p1        <= 1'b0;
      line_run     <= '0;
      pix_run      <= '0;
      pix_err      <= 1'b0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      frame_cnt_o  <= '0;
      line_cnt_o   <= '0;
    end else begin
      fv_p1        <= fv_i;
      lv_p1        <= lv_i;
      line_run     <= line_nxt;
      pix_run      <= pix_nxt;
      pix_err      <= pix_err_nxt;
      frame_done_o <= frame_end;
      frame_err_o  <= err_pulse;
      if (frame_end) begin
        line_cnt_o  <= line_nxt;
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end

  // Capture window: armed on accept, opens on the next frame start and
  // closes when the requested number of frames has ended
  always_ff @(posedge clk_pixel_i) begin
    if (reset_i || leave_live) begin
      capture_busy_o <= 1'b0;
      capture_en_o   <= 1'b0;
      cap_rem        <= '0;
    end else if (live) begin
      if (accept) begin
        capture_busy_o <= 1'b1;
        cap_rem        <= capture_frames_i;
      end else if (capture_busy_o && !capture_en_o && fv_rise) begin
        capture_en_o <= 1'b1;
      end else if (capture_en_o && fv_fall) begin
        if (cap_rem == 8'd1) begin
          capture_en_o   <= 1'b0;
          capture_busy_o <= 1'b0;
          cap_rem        <= '0;
        end else begin
          cap_rem <= cap_rem - 8'd1;
        end
      end
    end
  end

`ifdef MIPI_LINK_STATS_EN
  logic [15:0] err_total;

  // Lifetime count of error pulses, cleared only by reset
  always_ff @(posedge clk_pixel_i) begin
    if (reset_i)        err_total <= '0;
    else if (err_pulse) err_total <= sat_inc16(err_total);
  end

  assign err_cnt_o = err_total;
`else
  assign err_cnt_o = 16'd0;
`endif

  assign state_o = state;

endmodule
